dsp_simd_addacc_pipe: RTL

- Parametrised successor to the single-lane, zero-latency DSP adder.
- Splits a packed data word into `lanes` independent lanes of `width` bits each, the same way the DSP SIMD modes do (ONE48/TWO24/FOUR12).
- Each lane does add, subtract, accumulate or accumulator-load, with a per-lane carry/borrow output.
- Results go through a configurable-depth pipeline with valid/ready flow control on both sides, so it drops into streaming datapaths.

---
 rtl/dsp_simd_addacc_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/dsp_simd_addacc_pipe.sv
// SIMD add/sub/accumulate datapath: `lanes` independent `width`-bit lanes with a
// per-lane accumulator, feeding a `latency`-deep valid/ready pipeline.

module dsp_simd_addacc_lane #(
  parameter int width = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             accept,
  input  logic [1:0]       op,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] res,
  output logic             cy
);
  logic [width-1:0] acc;
  logic [width:0]   sum;

  // width+1 bit result: the top bit is carry-out for add/acc and borrow for sub
  always_comb begin
    case (op)
      2'b00:   sum = {1'b0, a} + {1'b0, b};
      2'b01:   sum = {1'b0, a} - {1'b0, b};
      2'b10:   sum = {1'b0, acc} + {1'b0, a};
      default: sum = {1'b0, a};
    endcase
  end

  assign res = sum[width-1:0];
  assign cy  = sum[width];

  // acc updates at accept, so back-to-back accumulates see the fresh value
  always_ff @(posedge clock) begin
    if (reset)                acc <= '0;
    else if (accept && op[1]) acc <= sum[width-1:0];
  end
endmodule

module dsp_simd_addacc_pipe #(
  parameter int width   = 12,
  parameter int lanes   = 4,
  parameter int latency = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic [width*lanes-1:0] a,
  input  logic [width*lanes-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [width*lanes-1:0] y,
  output logic [lanes-1:0]       carry
);
  if (!(lanes == 1 || lanes == 2 || lanes == 4)) begin : g_bad_lanes
    $error("dsp_simd_addacc_pipe: lanes must be 1, 2 or 4");
  end
  if (width * lanes > 48) begin : g_bad_width
    $error("dsp_simd_addacc_pipe: width*lanes must not exceed 48");
  end
  if (latency < 1 || latency > 3) begin : g_bad_latency
    $error("dsp_simd_addacc_pipe: latency must be 1..3");
  end

  typedef struct packed {
    logic [lanes-1:0][width-1:0] y;
    logic [lanes-1:0]            c;
  } res_t;

  logic                        advance;
  logic                        accept;
  logic [lanes-1:0][width-1:0] lane_y;
  logic [lanes-1:0]            lane_c;
  res_t                        lane_res;
  logic [latency:1]            vld_pipe;
  res_t [latency:1]            res_pipe;

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance & ~reset;
  assign accept   = in_valid & in_ready;

  for (genvar i = 0; i < lanes; i++) begin : g_lane
    dsp_simd_addacc_lane #(.width(width)) u_lane (
      .clock  (clock),
      .reset  (reset),
      .accept (accept),
      .op     (op),
      .a      (a[i*width +: width]),
      .b      (b[i*width +: width]),
      .res    (lane_y[i]),
      .cy     (lane_c[i])
    );
  end

  assign lane_res.y = lane_y;
  assign lane_res.c = lane_c;

  // Global stall: all stages move together; bubbles carry zero data
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      res_pipe <= '0;
    end else if (advance) begin
      vld_pipe[1] <= accept;
      res_pipe[1] <= accept ? lane_res : '0;
      for (int k = 2; k <= latency; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        res_pipe[k] <= res_pipe[k-1];
      end
    end
  end

  assign out_valid = vld_pipe[latency];
  assign y         = res_pipe[latency].y;
  assign carry     = res_pipe[latency].c;
endmodule
